lc_token_loader: RTL

LC_TOKEN_LOADER -- requirements
Module: lc_token_loader

---
 rtl/lc_token_loader_if.sv | 30 +++
 rtl/lc_token_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/lc_token_loader_if.sv
// Host token / lifecycle-stage bundle for lc_token_loader.
// slave = the loader, master = the host plus lifecycle stage that drive it.
interface lc_token_loader_if #(
  parameter int WORD_W = 32
);
  logic              tok_valid;
  logic [WORD_W-1:0] tok_data;
  logic              tok_ready;
  logic              tok_abort;
  logic              lc_transition_request;
  logic [511:0]      lc_identifier;
  logic              lc_done;
  logic              lc_success;
  logic [2:0]        lc_state;
  logic              resp_valid;
  logic              resp_success;
  logic              locked;

  modport slave (
    input  tok_valid, tok_data, tok_abort, lc_done, lc_success, lc_state,
    output tok_ready, lc_transition_request, lc_identifier, resp_valid,
    resp_success, locked
  );

  modport master (
    output tok_valid, tok_data, tok_abort, lc_done, lc_success, lc_state,
    input  tok_ready, lc_transition_request, lc_identifier, resp_valid,
    resp_success, locked
  );
endinterface

// File: rtl/lc_token_loader.sv
// Assembles a 512-bit owner token from host words and runs it past the lifecycle stage.
// Define LC_LOCKOUT_EN to latch a lockout after MAX_FAILS failed authentications.
module lc_token_loader #(
  parameter int WORD_W    = 32,
  parameter int MAX_FAILS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  lc_token_loader_if.slave  bus
);
  localparam int NB    = 512 / WORD_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  if ((512 % WORD_W) != 0) begin : g_bad_word_w
    $error("WORD_W must divide 512");
  end
  if (MAX_FAILS < 1 || MAX_FAILS > 15) begin : g_bad_max_fails
    $error("MAX_FAILS must be in 1..15");
  end

  typedef enum logic [2:0] {IDLE, LOAD, REQ, RELEASE, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [511:0]       ident_q, ident_d;
  logic               req_q, req_d;
  logic               rv_q, rv_d;
  logic               rs_q, rs_d;
  logic [3:0]         fail_q, fail_d;
  logic               locked_q, locked_d;
  logic               rdy_q, rdy_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ident_d  = ident_q;
    req_d    = req_q;
    rv_d     = rv_q;
    rs_d     = rs_q;
    fail_d   = fail_q;
    case (state_q)
      IDLE, LOAD: begin
        // abort beats a simultaneous word
        if (bus.tok_abort) begin
          state_d = IDLE;
          idx_d   = '0;
          ident_d = '0;
        end else if (bus.tok_valid && rdy_q) begin
          ident_d[idx_q*WORD_W +: WORD_W] = bus.tok_data;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bus.lc_state == 3'b101) begin
              state_d = RESP;
              rv_d    = 1'b1;
              rs_d    = 1'b0;
            end else begin
              state_d = REQ;
              req_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      REQ: begin
        if (bus.lc_done) begin
          req_d   = 1'b0;
          rs_d    = bus.lc_success;
          state_d = RELEASE;
          if (bus.lc_success)       fail_d = '0;
          else if (fail_q != 4'hF)  fail_d = fail_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!bus.lc_done) begin
          state_d = RESP;
          rv_d    = 1'b1;
        end
      end
      RESP: begin
        rv_d    = 1'b0;
        ident_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef LC_LOCKOUT_EN
    locked_d = locked_q | (fail_d >= 4'(MAX_FAILS));
`else
    locked_d = 1'b0;
`endif
    rdy_d = ((state_d == IDLE) || (state_d == LOAD)) && !locked_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ident_q  <= '0;
      req_q    <= 1'b0;
      rv_q     <= 1'b0;
      rs_q     <= 1'b0;
      fail_q   <= '0;
      locked_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ident_q  <= ident_d;
      req_q    <= req_d;
      rv_q     <= rv_d;
      rs_q     <= rs_d;
      fail_q   <= fail_d;
      locked_q <= locked_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.tok_ready             = rdy_q;
  assign bus.lc_transition_request = req_q;
  assign bus.lc_identifier         = ident_q;
  assign bus.resp_valid            = rv_q;
  assign bus.resp_success          = rs_q;
  assign bus.locked                = locked_q;
endmodule
